// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_ctrl_pkg: cause codes, commit flag indices and decode helper (rev 1.0)
// ---------------------------------------------------------------------------
package exc_ctrl_pkg;

  localparam int ExceptionCauseWidth   = 4;
  localparam int EXC_VEC_W_DEFAULT     = 16;
  localparam int FLUSH_CYCLES_DEFAULT  = 2;

  typedef enum logic [ExceptionCauseWidth-1:0] {
    EXCEPTION_INT  = 4'd0,
    EXCEPTION_PIL  = 4'd1,
    EXCEPTION_PIS  = 4'd2,
    EXCEPTION_PIF  = 4'd3,
    EXCEPTION_PME  = 4'd4,
    EXCEPTION_PPI  = 4'd5,
    EXCEPTION_ADEF = 4'd6,
    EXCEPTION_ADEM = 4'd7,
    EXCEPTION_ALE  = 4'd8,
    EXCEPTION_SYS  = 4'd9,
    EXCEPTION_BRK  = 4'd10,
    EXCEPTION_INE  = 4'd11,
    EXCEPTION_IPE  = 4'd12,
    EXCEPTION_TLBR = 4'd13
  } exc_cause_e;

  // commit_exc_vec bit positions; lower index wins
  localparam int EXC_ADEF  = 0;
  localparam int EXC_ITLBR = 1;
  localparam int EXC_PIF   = 2;
  localparam int EXC_IPPI  = 3;
  localparam int EXC_INE   = 4;
  localparam int EXC_IPE   = 5;
  localparam int EXC_SYS   = 6;
  localparam int EXC_BRK   = 7;
  localparam int EXC_ALE   = 8;
  localparam int EXC_ADEM  = 9;
  localparam int EXC_DTLBR = 10;
  localparam int EXC_PIL   = 11;
  localparam int EXC_PIS   = 12;
  localparam int EXC_PME   = 13;
  localparam int EXC_DPPI  = 14;
  localparam int EXC_RSV   = 15;

  typedef enum logic [1:0] {
    ADDR_ZERO = 2'd0,
    ADDR_PC   = 2'd1,
    ADDR_BADV = 2'd2
  } addr_sel_e;

  typedef struct packed {
    logic       evt;
    logic       ertn;
    logic       tlbr;
    addr_sel_e  addr_sel;
    exc_cause_e cause;
  } prio_res_t;

  function automatic prio_res_t exc_decode(input int idx);
    prio_res_t r;
    r     = '0;
    r.evt = 1'b1;
    case (idx)
      EXC_ADEF:  begin r.cause = EXCEPTION_ADEF; r.addr_sel = ADDR_PC;   end
      EXC_ITLBR: begin r.cause = EXCEPTION_TLBR; r.addr_sel = ADDR_PC;   r.tlbr = 1'b1; end
      EXC_PIF:   begin r.cause = EXCEPTION_PIF;  r.addr_sel = ADDR_PC;   end
      EXC_IPPI:  begin r.cause = EXCEPTION_PPI;  r.addr_sel = ADDR_PC;   end
      EXC_INE:   r.cause = EXCEPTION_INE;
      EXC_IPE:   r.cause = EXCEPTION_IPE;
      EXC_SYS:   r.cause = EXCEPTION_SYS;
      EXC_BRK:   r.cause = EXCEPTION_BRK;
      EXC_ALE:   begin r.cause = EXCEPTION_ALE;  r.addr_sel = ADDR_BADV; end
      EXC_ADEM:  begin r.cause = EXCEPTION_ADEM; r.addr_sel = ADDR_BADV; end
      EXC_DTLBR: begin r.cause = EXCEPTION_TLBR; r.addr_sel = ADDR_BADV; r.tlbr = 1'b1; end
      EXC_PIL:   begin r.cause = EXCEPTION_PIL;  r.addr_sel = ADDR_BADV; end
      EXC_PIS:   begin r.cause = EXCEPTION_PIS;  r.addr_sel = ADDR_BADV; end
      EXC_PME:   begin r.cause = EXCEPTION_PME;  r.addr_sel = ADDR_BADV; end
      EXC_DPPI:  begin r.cause = EXCEPTION_PPI;  r.addr_sel = ADDR_BADV; end
      default:   r.evt = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_ctrl_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_prio_enc: picks the commit event (INT > lowest flag > ERTN) (rev 1.0)
// ---------------------------------------------------------------------------
module exc_prio_enc
  import exc_ctrl_pkg::*;
#(
  parameter int VEC_W = EXC_VEC_W_DEFAULT
) (
  input  logic [VEC_W-1:0] vec,
  input  logic             int_pend,
  input  logic             ertn,
  output prio_res_t        res
);

  prio_res_t flag;

  always_comb begin
    res  = '0;
    flag = '0;
    if (ertn) begin
      res.evt  = 1'b1;
      res.ertn = 1'b1;
    end
    // walk downwards so the lowest set index is the one left in res
    for (int i = VEC_W - 1; i >= 0; i--) begin
      flag = exc_decode(i);
      if (vec[i] && flag.evt) res = flag;
    end
    if (int_pend) begin
      res       = '0;
      res.evt   = 1'b1;
      res.cause = EXCEPTION_INT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_ctrl: exception/interrupt commit controller with flush/redirect (rev 1.0)
// ---------------------------------------------------------------------------
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int EXC_VEC_W    = EXC_VEC_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           commit_valid,
  output logic                           commit_ready,
  input  logic [31:0]                    commit_pc,
  input  logic [EXC_VEC_W-1:0]           commit_exc_vec,
  input  logic [31:0]                    commit_badv,
  input  logic                           commit_is_ertn,
  input  logic [11:0]                    ecfg_lie,
  input  logic [11:0]                    estat_is,
  input  logic                           crmd_ie,
  input  logic [31:0]                    eentry_va,
  input  logic [31:0]                    tlbrentry_va,
  input  logic [31:0]                    era_pc,
  output logic                           is_exception,
  output logic [ExceptionCauseWidth-1:0] exception_cause,
  output logic [31:0]                    exception_pc,
  output logic [31:0]                    exception_addr,
  output logic                           is_ertn,
  output logic                           flush,
  output logic                           redirect_valid,
  output logic [31:0]                    redirect_pc
);

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             int_pend;
  prio_res_t        sel;

  exc_prio_enc #(.VEC_W(EXC_VEC_W)) u_prio (
    .vec      (commit_exc_vec),
    .int_pend (int_pend),
    .ertn     (commit_is_ertn),
    .res      (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      int_pend        <= 1'b0;
      commit_ready    <= 1'b1;
      is_exception    <= 1'b0;
      exception_cause <= '0;
      exception_pc    <= '0;
      exception_addr  <= '0;
      is_ertn         <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      // registered so the CSR->commit path is cut; costs one cycle of latency
      int_pend       <= crmd_ie & |(ecfg_lie & estat_is);
      is_exception   <= 1'b0;
      is_ertn        <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (commit_valid && commit_ready && sel.evt) begin
            state          <= ST_FLUSH;
            cnt            <= CNT_LOAD;
            flush          <= 1'b1;
            commit_ready   <= 1'b0;
            redirect_valid <= 1'b1;
            if (sel.ertn) begin
              is_ertn     <= 1'b1;
              redirect_pc <= era_pc;
            end else begin
              is_exception    <= 1'b1;
              exception_cause <= sel.cause;
              exception_pc    <= commit_pc;
              case (sel.addr_sel)
                ADDR_PC:   exception_addr <= commit_pc;
                ADDR_BADV: exception_addr <= commit_badv;
                default:   exception_addr <= '0;
              endcase
              redirect_pc <= sel.tlbr ? tlbrentry_va : eentry_va;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state        <= ST_IDLE;
            flush        <= 1'b0;
            commit_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_exc_ctrl: scoreboard bench with directed and random commit traffic (rev 1.0)
// ---------------------------------------------------------------------------
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam int FC   = 2;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic [15:0] commit_exc_vec;
  logic [31:0] commit_badv;
  logic        commit_is_ertn;
  logic [11:0] ecfg_lie;
  logic [11:0] estat_is;
  logic        crmd_ie;
  logic [31:0] eentry_va;
  logic [31:0] tlbrentry_va;
  logic [31:0] era_pc;
  logic        is_exception;
  logic [ExceptionCauseWidth-1:0] exception_cause;
  logic [31:0] exception_pc;
  logic [31:0] exception_addr;
  logic        is_ertn;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  exc_ctrl #(.FLUSH_CYCLES(FC), .EXC_VEC_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .commit_pc      (commit_pc),
    .commit_exc_vec (commit_exc_vec),
    .commit_badv    (commit_badv),
    .commit_is_ertn (commit_is_ertn),
    .ecfg_lie       (ecfg_lie),
    .estat_is       (estat_is),
    .crmd_ie        (crmd_ie),
    .eentry_va      (eentry_va),
    .tlbrentry_va   (tlbrentry_va),
    .era_pc         (era_pc),
    .is_exception   (is_exception),
    .exception_cause(exception_cause),
    .exception_pc   (exception_pc),
    .exception_addr (exception_addr),
    .is_ertn        (is_ertn),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          is_exc;
    bit          is_ertn;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  exp_t mon_r;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   exp_flush [0:MAXC-1];
  bit   exp_chk   [0:MAXC-1];
  bit   model_pend;
  int   next_free;
  int   flush_until;
  bit   last_accept;

  // architectural cause for each commit flag bit
  exc_cause_e cause_tab [0:14] = '{EXCEPTION_ADEF, EXCEPTION_TLBR, EXCEPTION_PIF, EXCEPTION_PPI,
                                   EXCEPTION_INE, EXCEPTION_IPE, EXCEPTION_SYS, EXCEPTION_BRK,
                                   EXCEPTION_ALE, EXCEPTION_ADEM, EXCEPTION_TLBR, EXCEPTION_PIL,
                                   EXCEPTION_PIS, EXCEPTION_PME, EXCEPTION_PPI};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  // Evaluates the reference model for the upcoming edge, then advances to it.
  task automatic tick();
    int   e;
    int   idx;
    exp_t r;
    e = cyc + 1;
    last_accept = 1'b0;
    if (rst) begin
      flush_until = 0;
      next_free   = e + 1;
      model_pend  = 1'b0;
      if (e < MAXC) exp_flush[e] = 1'b0;
    end else begin
      if (commit_valid && e >= next_free) begin
        last_accept = 1'b1;
        idx = -1;
        for (int i = 14; i >= 0; i--) if (commit_exc_vec[i]) idx = i;
        r.tag = e; r.is_exc = 1'b0; r.is_ertn = 1'b0;
        r.cause = '0; r.pc = '0; r.addr = '0; r.rpc = '0;
        if (model_pend) begin
          r.is_exc = 1'b1; r.cause = EXCEPTION_INT; r.pc = commit_pc; r.rpc = eentry_va;
        end else if (idx >= 0) begin
          r.is_exc = 1'b1;
          r.cause  = cause_tab[idx];
          r.pc     = commit_pc;
          r.addr   = (idx <= 3) ? commit_pc : (idx >= 8) ? commit_badv : 32'h0;
          r.rpc    = (idx == 1 || idx == 10) ? tlbrentry_va : eentry_va;
        end else if (commit_is_ertn) begin
          r.is_ertn = 1'b1; r.rpc = era_pc;
        end
        if (r.is_exc || r.is_ertn) begin
          q.push_back(r);
          flush_until = e + FC;
          next_free   = e + FC + 1;
        end
      end
      if (e < MAXC) exp_flush[e] = (e < flush_until);
      model_pend = crmd_ie && ((ecfg_lie & estat_is) != 12'h0);
    end
    if (e < MAXC) exp_chk[e] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    commit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [15:0] vec,
                        input logic [31:0] badv, input logic ertn);
    commit_valid = 1'b1; commit_pc = pc; commit_exc_vec = vec;
    commit_badv = badv; commit_is_ertn = ertn;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_accept) break;
    end
    chk("commit_accepted", 32'(last_accept), 32'd1);
    commit_valid = 1'b0; commit_exc_vec = '0; commit_is_ertn = 1'b0;
  endtask

  // Monitor: per-cycle flush/ready expectations and scoreboard on pulses.
  always @(negedge clk) begin
    if (cyc < MAXC && exp_chk[cyc]) begin
      chk("flush", 32'(flush), 32'(exp_flush[cyc]));
      chk("commit_ready", 32'(commit_ready), 32'(!exp_flush[cyc]));
    end
    while (q.size() > 0 && q[0].tag < cyc) begin
      tests++; fails++;
      $display("FAIL missing_event: got no pulse expected event at cycle %0d", q[0].tag);
      void'(q.pop_front());
    end
    if (is_exception === 1'b1 || is_ertn === 1'b1 || redirect_valid === 1'b1) begin
      if (q.size() == 0 || q[0].tag != cyc) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got exc=%b ertn=%b redir=%b expected none (cycle %0d)",
                 is_exception, is_ertn, redirect_valid, cyc);
      end else begin
        mon_r = q.pop_front();
        chk("is_exception", 32'(is_exception), 32'(mon_r.is_exc));
        chk("is_ertn", 32'(is_ertn), 32'(mon_r.is_ertn));
        chk("redirect_valid", 32'(redirect_valid), 32'd1);
        chk("redirect_pc", redirect_pc, mon_r.rpc);
        if (mon_r.is_exc) begin
          chk("exception_cause", 32'(exception_cause), 32'(mon_r.cause));
          chk("exception_pc", exception_pc, mon_r.pc);
          chk("exception_addr", exception_addr, mon_r.addr);
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_exc_vec = '0;
    commit_badv = '0; commit_is_ertn = 1'b0; ecfg_lie = '0; estat_is = '0;
    crmd_ie = 1'b0; eentry_va = 32'h1C008000; tlbrentry_va = 32'h1C00F000;
    era_pc = 32'h1C000204;
    model_pend = 1'b0; next_free = 0; flush_until = 0;
    for (int i = 0; i < MAXC; i++) begin exp_flush[i] = 1'b0; exp_chk[i] = 1'b0; end
    #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    commit(32'h1C000100, 16'h0040, 32'h0, 1'b0);                 // SYS
    idle(4);
    commit(32'h1C000104, 16'h0110, 32'h80000003, 1'b0);          // ALE + INE -> INE
    idle(4);
    commit(32'h1C000108, 16'h0400, 32'h00400010, 1'b0);          // DTLBR
    idle(4);
    commit(32'h1C000200, 16'h0000, 32'h0, 1'b1);                 // ERTN
    idle(4);
    commit(32'h1C000200, 16'h0020, 32'h0, 1'b1);                 // ERTN + IPE
    idle(4);

    crmd_ie = 1'b1; ecfg_lie = 12'h800; estat_is = 12'h800;
    idle(2);
    commit(32'h1C000300, 16'h0040, 32'h0, 1'b0);                 // INT beats SYS
    estat_is = 12'h0;
    idle(4);
    crmd_ie = 1'b0; estat_is = 12'h800;
    idle(2);
    commit(32'h1C000304, 16'h0000, 32'h0, 1'b0);                 // masked: no event
    estat_is = 12'h0; ecfg_lie = 12'h0;
    idle(4);

    commit(32'h1C000400, 16'h0040, 32'h0, 1'b0);                 // reset during flush
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);

    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_pc    = $urandom;
      commit_badv  = $urandom;
      v = '0;
      if ($urandom_range(0, 2) == 0) v = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) v = v | (16'h1 << $urandom_range(0, 15));
      commit_exc_vec = v;
      commit_is_ertn = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) begin
        eentry_va    = $urandom;
        tlbrentry_va = $urandom;
        era_pc       = $urandom;
        crmd_ie      = $urandom_range(0, 1) == 1;
        ecfg_lie     = 12'($urandom);
        estat_is     = ($urandom_range(0, 3) == 0) ? (12'h1 << $urandom_range(0, 11)) : 12'h0;
      end
      tick();
    end
    rst = 1'b0;
    idle(8);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
